data_cache: RTL

//  Direct-mapped, write-through, no-write-allocate data cache on the Riscv151

---
 rtl/data_cache.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Lines hold four 32-bit words. The core is stalled whenever the cache is
// talking to main memory; read hits return data one cycle after acceptance.
module data_cache #(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  cpu_addr,
    input  logic         cpu_re,
    input  logic [3:0]   cpu_we,
    input  logic [31:0]  cpu_din,
    output logic [31:0]  cpu_dout,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_rw,
    output logic [27:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    output logic [15:0]  mem_req_mask,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2,
        WRITE_REQ = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Cache storage: valid bits are control (reset), tags and lines are data.
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     line_q [LINES];

    // Registered copy of the accepted request; the memory side only uses these.
    logic [27:0] req_line;
    logic [1:0]  req_word;
    logic [31:0] req_din;
    logic [3:0]  req_we;

    // Decode of the live core request.
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [1:0]       cpu_word;
    logic             is_write;
    logic             is_read;
    logic             accept;
    logic             cpu_hit;
    logic             rd_hit;
    logic             wr_hit;
    logic [127:0]     hit_line;
    logic [31:0]      hit_word;
    logic [31:0]      merge_word;

    // Decode of the registered request for the fill path.
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      fill_word;
    logic             fill_done;

    // Byte offset bits are never used; the core aligns data itself.
    logic unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_idx  = cpu_addr[4 +: IDX_W];
    assign cpu_tag  = cpu_addr[31 -: TAG_W];
    assign cpu_word = cpu_addr[3:2];

    // A store wins over a load when both are asserted.
    assign is_write = |cpu_we;
    assign is_read  = cpu_re & ~is_write;
    assign accept   = (state == IDLE) & (is_write | cpu_re);

    assign hit_line = line_q[cpu_idx];
    assign hit_word = hit_line[{cpu_word, 5'b0} +: 32];
    assign cpu_hit  = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign rd_hit   = accept & is_read & cpu_hit;
    assign wr_hit   = accept & is_write & cpu_hit;

    assign req_idx   = req_line[IDX_W-1:0];
    assign req_tag   = req_line[27 -: TAG_W];
    assign fill_word = mem_resp_data[{req_word, 5'b0} +: 32];
    assign fill_done = (state == FILL_WAIT) & mem_resp_valid;

    // Byte-merge the store data into the currently cached word.
    always_comb begin
        merge_word = hit_word;
        for (int b = 0; b < 4; b++) begin
            if (cpu_we[b]) begin
                merge_word[8*b +: 8] = cpu_din[8*b +: 8];
            end
        end
    end

    // State register; reset aborts any memory transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory request outputs; request fields come only from
    // the registered copy so they stay stable until the handshake.
    always_comb begin
        state_nxt     = state;
        stall         = (state != IDLE);
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = req_line;
        mem_req_data  = '0;
        mem_req_mask  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_write) begin
                        state_nxt = WRITE_REQ;
                    end else if (!cpu_hit) begin
                        state_nxt = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            WRITE_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_data  = {96'b0, req_din} << {req_word, 5'b0};
                mem_req_mask  = {12'b0, req_we} << {req_word, 2'b0};
                if (mem_req_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Valid bits and load data: updated on read hits and on fill completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= '0;
            cpu_dout <= '0;
        end else begin
            if (rd_hit) begin
                cpu_dout <= hit_word;
            end
            if (fill_done) begin
                valid_q[req_idx] <= 1'b1;
                cpu_dout         <= fill_word;
            end
        end
    end

    // Request capture at accept; a stale valid bit makes these safe without reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_line <= cpu_addr[31:4];
            req_word <= cpu_word;
            req_din  <= cpu_din;
            req_we   <= cpu_we;
        end
    end

    // Tag and line storage: fills replace the whole line, store hits merge a word.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[req_idx]  <= req_tag;
            line_q[req_idx] <= mem_resp_data;
        end
        if (wr_hit) begin
            line_q[cpu_idx][{cpu_word, 5'b0} +: 32] <= merge_word;
        end
    end

endmodule
